// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative HI/LO multiply/divide unit: MIPS funct
// codes, FSM and datapath-mode encodings, and a small magnitude helper.
package mult_div_unit_pkg;

    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    localparam int DIV_STEPS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_t;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } md_mode_t;

    // Unsigned ops pass through untouched; 0x80000000 maps to itself, which is
    // the correct magnitude when read back as unsigned.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning architectural HI/LO.
// EX issues with go and stalls on hold; abort cancels an op before it commits.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MUL_BITS = 1   // 1, 2 or 4 multiplier bits per cycle
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        go,
    input  logic [5:0]  fn,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic        abort,
    output logic        hold,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int         MUL_STEPS    = 32 / MUL_BITS;
    localparam logic [5:0] MUL_CNT_INIT = 6'(MUL_STEPS - 1);
    localparam logic [5:0] DIV_CNT_INIT = 6'(DIV_STEPS - 1);

    md_state_t   state_reg;
    md_mode_t    mode_reg;
    logic [5:0]  cnt_reg;
    logic        neg_q_reg;
    logic        neg_r_reg;
    logic        done_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;

    logic [63:0] mcand_reg;
    logic [31:0] mplier_reg;
    logic [63:0] prod_reg;
    logic [31:0] dvs_reg;
    logic [31:0] quo_reg;
    logic [31:0] rem_reg;

    logic [63:0] mcand_next;
    logic [31:0] mplier_next;
    logic [63:0] prod_next;
    logic [31:0] quo_next;
    logic [31:0] rem_next;

    // Issue decode
    logic        is_mul_op;
    logic        is_div_op;
    logic        is_signed_op;
    logic        op2_zero;
    logic [31:0] mag1;
    logic [31:0] mag2;

    assign is_mul_op    = (fn == FN_MULT) || (fn == FN_MULTU);
    assign is_div_op    = (fn == FN_DIV)  || (fn == FN_DIVU);
    assign is_signed_op = (fn == FN_MULT) || (fn == FN_DIV);
    assign op2_zero     = (op2 == 32'd0);
    assign mag1         = mag32(op1, is_signed_op);
    assign mag2         = mag32(op2, is_signed_op);

    // Partial products for the MUL_BITS multiplier bits retired this cycle
    logic [63:0] pp [MUL_BITS];
    logic [63:0] pp_sum;

    generate
        for (genvar gi = 0; gi < MUL_BITS; gi++) begin : g_pp
            assign pp[gi] = mplier_reg[gi] ? (mcand_reg << gi) : 64'd0;
        end
    endgenerate

    always_comb begin
        pp_sum = 64'd0;
        for (int i = 0; i < MUL_BITS; i++) begin
            pp_sum = pp_sum + pp[i];
        end
    end

    // Restoring divide: the shifted partial remainder needs 33 bits because it
    // can reach 2*divisor-1 before the trial subtraction.
    logic [32:0] rem_shift;
    logic [32:0] rem_diff;

    assign rem_shift = {rem_reg, quo_reg[31]};
    assign rem_diff  = rem_shift - {1'b0, dvs_reg};

    always_comb begin
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        prod_next   = prod_reg;
        quo_next    = quo_reg;
        rem_next    = rem_reg;
        if (mode_reg == MODE_MUL) begin
            prod_next   = prod_reg + pp_sum;
            mcand_next  = mcand_reg << MUL_BITS;
            mplier_next = mplier_reg >> MUL_BITS;
        end else if (!rem_diff[32]) begin
            rem_next = rem_diff[31:0];
            quo_next = {quo_reg[30:0], 1'b1};
        end else begin
            rem_next = rem_shift[31:0];
            quo_next = {quo_reg[30:0], 1'b0};
        end
    end

    // Sign fixup applied only in FIX
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign prod_fix = neg_q_reg ? (~prod_reg + 64'd1) : prod_reg;
    assign quo_fix  = neg_q_reg ? (~quo_reg + 32'd1)  : quo_reg;
    assign rem_fix  = neg_r_reg ? (~rem_reg + 32'd1)  : rem_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ST_IDLE;
            mode_reg   <= MODE_MUL;
            cnt_reg    <= 6'd0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            done_reg   <= 1'b0;
            hi_reg     <= 32'd0;
            lo_reg     <= 32'd0;
            mcand_reg  <= 64'd0;
            mplier_reg <= 32'd0;
            prod_reg   <= 64'd0;
            dvs_reg    <= 32'd0;
            quo_reg    <= 32'd0;
            rem_reg    <= 32'd0;
        end else begin
            done_reg <= 1'b0;
            if (abort) begin
                state_reg <= ST_IDLE;
            end else begin
                unique case (state_reg)
                    ST_IDLE: begin
                        if (go) begin
                            if (fn == FN_MTHI) begin
                                hi_reg <= op1;
                            end else if (fn == FN_MTLO) begin
                                lo_reg <= op1;
                            end else if (is_mul_op) begin
                                state_reg  <= ST_MUL;
                                mode_reg   <= MODE_MUL;
                                cnt_reg    <= MUL_CNT_INIT;
                                mcand_reg  <= {32'd0, mag1};
                                mplier_reg <= mag2;
                                prod_reg   <= 64'd0;
                                neg_q_reg  <= is_signed_op & (op1[31] ^ op2[31]);
                                neg_r_reg  <= is_signed_op & op1[31];
                            end else if (is_div_op) begin
                                state_reg <= ST_DIV;
                                mode_reg  <= MODE_DIV;
                                cnt_reg   <= DIV_CNT_INIT;
                                quo_reg   <= mag1;
                                dvs_reg   <= mag2;
                                rem_reg   <= 32'd0;
                                // Divide by zero leaves the all-ones quotient unsigned;
                                // the remainder fixup still reproduces op1 exactly.
                                neg_q_reg <= is_signed_op & (op1[31] ^ op2[31]) & ~op2_zero;
                                neg_r_reg <= is_signed_op & op1[31];
                            end
                        end
                    end
                    ST_MUL, ST_DIV: begin
                        mcand_reg  <= mcand_next;
                        mplier_reg <= mplier_next;
                        prod_reg   <= prod_next;
                        quo_reg    <= quo_next;
                        rem_reg    <= rem_next;
                        if (cnt_reg == 6'd0) begin
                            state_reg <= ST_FIX;
                        end else begin
                            cnt_reg <= cnt_reg - 6'd1;
                        end
                    end
                    ST_FIX: begin
                        if (mode_reg == MODE_MUL) begin
                            {hi_reg, lo_reg} <= prod_fix;
                        end else begin
                            lo_reg <= quo_fix;
                            hi_reg <= rem_fix;
                        end
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign hold = (state_reg != ST_IDLE);
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

    // Issuing while busy is a protocol violation on the EX side.
    a_no_go_while_hold: assert property (@(posedge clock) disable iff (!reset_n) !(go && hold));

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: one instance at 1 bit/cycle, one at 4
// bits/cycle; directed ops push expected HI/LO and latency, monitors pop on done.
`timescale 1ns/1ps
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        go, go4, abort, abort4;
    logic [5:0]  fn;
    logic [31:0] op1, op2;
    logic        hold, done, hold4, done4;
    logic [31:0] hi, lo, hi4, lo4;

    always #5 clock = ~clock;

    mult_div_unit #(.MUL_BITS(1)) dut (
        .clock(clock), .reset_n(reset_n), .go(go), .fn(fn), .op1(op1), .op2(op2),
        .abort(abort), .hold(hold), .done(done), .hi(hi), .lo(lo)
    );

    mult_div_unit #(.MUL_BITS(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .go(go4), .fn(fn), .op1(op1), .op2(op2),
        .abort(abort4), .hold(hold4), .done(done4), .hi(hi4), .lo(lo4)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          issue;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t sb4[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitors: pop one expectation per done pulse
    always @(negedge clock) begin : mon1
        exp_t e;
        if (reset_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut unexpected done: hi=%h lo=%h, no op outstanding", hi, lo);
            end else begin
                e = sb.pop_front();
                check({e.name, " hi"}, hi, e.hi);
                check({e.name, " lo"}, lo, e.lo);
                check({e.name, " latency"}, 32'(cyc - e.issue), 32'(e.lat));
                check({e.name, " hold at done"}, 32'(hold), 32'd0);
                $display("dut  %-22s hi=%h lo=%h latency=%0d", e.name, hi, lo, cyc - e.issue);
            end
        end
    end

    always @(negedge clock) begin : mon4
        exp_t e;
        if (reset_n === 1'b1 && done4 === 1'b1) begin
            if (sb4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut4 unexpected done: hi=%h lo=%h, no op outstanding", hi4, lo4);
            end else begin
                e = sb4.pop_front();
                check({e.name, " hi"}, hi4, e.hi);
                check({e.name, " lo"}, lo4, e.lo);
                check({e.name, " latency"}, 32'(cyc - e.issue), 32'(e.lat));
                check({e.name, " hold at done"}, 32'(hold4), 32'd0);
                $display("dut4 %-22s hi=%h lo=%h latency=%0d", e.name, hi4, lo4, cyc - e.issue);
            end
        end
    end

    // Drive one go cycle; leaves the caller at the negedge after the accepting edge.
    task automatic issue(input bit on4, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input bit expect_done,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input int lat, input string name);
        exp_t e;
        @(negedge clock);
        fn  = f;
        op1 = a;
        op2 = b;
        if (on4) go4 = 1'b1;
        else     go  = 1'b1;
        if (expect_done) begin
            e.hi    = ehi;
            e.lo    = elo;
            e.issue = cyc + 1;
            e.lat   = lat;
            e.name  = name;
            if (on4) sb4.push_back(e);
            else     sb.push_back(e);
        end
        @(negedge clock);
        go  = 1'b0;
        go4 = 1'b0;
        check({name, " hold after go"}, 32'(on4 ? hold4 : hold), 32'd1);
    endtask

    task automatic wait_idle(input bit on4, input string name);
        int n = 0;
        while ((on4 ? hold4 : hold) !== 1'b0 && n < 60) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL %s timeout: hold still high after %0d cycles, expected low", name, n);
        end
        @(negedge clock);
        check({name, " result delivered"}, 32'(on4 ? sb4.size() : sb.size()), 32'd0);
    endtask

    task automatic run_op(input bit on4, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi,
                          input logic [31:0] elo, input int lat, input string name);
        issue(on4, f, a, b, 1'b1, ehi, elo, lat, name);
        wait_idle(on4, name);
    endtask

    initial begin
        reset_n = 1'b0;
        go = 1'b0; go4 = 1'b0; abort = 1'b0; abort4 = 1'b0;
        fn = 6'd0; op1 = 32'd0; op2 = 32'd0;
        repeat (3) @(negedge clock);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset hold", 32'(hold), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset hold4", 32'(hold4), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Multiply, 1 bit/cycle
        run_op(0, FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, "MULTU max*max");
        run_op(0, FN_MULT,  32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFEB, 33, "MULT -7*3");
        run_op(0, FN_MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 33, "MULT maxpos*minneg");

        // Divide
        run_op(0, FN_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, "DIV -7/2");
        run_op(0, FN_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33, "DIVU 100/7");
        run_op(0, FN_DIV,   32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, 33, "DIV 100/-7");
        run_op(0, FN_DIVU,  32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF, 33, "DIVU max/16");
        run_op(0, FN_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 33, "DIV 5/0");
        run_op(0, FN_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 33, "DIV -5/0");
        run_op(0, FN_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 33, "DIV minneg/-1");

        // Multiply, 4 bits/cycle
        run_op(1, FN_MULT,  32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFEB, 9,  "MULT4 -7*3");
        run_op(1, FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 9,  "MULTU4 max*max");
        run_op(1, FN_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, "DIV4 -7/2");

        // MTHI / MTLO write immediately without hold or done
        @(negedge clock);
        fn = FN_MTHI; op1 = 32'h1234; go = 1'b1;
        @(negedge clock);
        fn = FN_MTLO; op1 = 32'h5678;
        check("MTHI hi", hi, 32'h1234);
        check("MTHI hold", 32'(hold), 32'd0);
        @(negedge clock);
        go = 1'b0;
        check("MTLO lo", lo, 32'h5678);
        $display("dut  MTHI/MTLO             hi=%h lo=%h", hi, lo);

        // go together with abort is dropped
        @(negedge clock);
        fn = FN_MTHI; op1 = 32'hDEAD; go = 1'b1; abort = 1'b1;
        @(negedge clock);
        go = 1'b0; abort = 1'b0;
        check("go+abort hi kept", hi, 32'h1234);
        check("go+abort hold", 32'(hold), 32'd0);

        // Abort mid-multiply at cycle 20
        issue(0, FN_MULT, 32'd2, 32'd3, 1'b0, 32'd0, 32'd0, 0, "MULT 2*3 abort@20");
        repeat (19) @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort@20 hold", 32'(hold), 32'd0);
        check("abort@20 hi", hi, 32'h1234);
        check("abort@20 lo", lo, 32'h5678);
        repeat (40) @(negedge clock);
        check("abort@20 hi later", hi, 32'h1234);
        $display("dut  MULT 2*3 aborted@20   hi=%h lo=%h", hi, lo);

        // Abort during FIX beats the commit
        issue(0, FN_MULT, 32'd2, 32'd3, 1'b0, 32'd0, 32'd0, 0, "MULT 2*3 abort@FIX");
        repeat (32) @(negedge clock);
        check("FIX hold", 32'(hold), 32'd1);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort@FIX hold", 32'(hold), 32'd0);
        check("abort@FIX hi", hi, 32'h1234);
        check("abort@FIX lo", lo, 32'h5678);
        repeat (5) @(negedge clock);
        $display("dut  MULT 2*3 aborted@FIX  hi=%h lo=%h", hi, lo);

        run_op(0, FN_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 33, "MULT -2*3 after abort");

        // Asynchronous reset mid-divide
        issue(0, FN_DIV, 32'h40000000, 32'd3, 1'b0, 32'd0, 32'd0, 0, "DIV lost to reset");
        repeat (9) @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset hold", 32'(hold), 32'd0);
        check("async reset hi", hi, 32'd0);
        check("async reset lo", lo, 32'd0);
        check("async reset hi4", hi4, 32'd0);
        $display("dut  reset mid-DIV         hi=%h lo=%h hold=%0d", hi, lo, hold);
        @(negedge clock);
        reset_n = 1'b1;
        run_op(0, FN_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 33, "DIVU 9/3 after reset");

        repeat (3) @(negedge clock);
        check("scoreboard dut drained", 32'(sb.size()), 32'd0);
        check("scoreboard dut4 drained", 32'(sb4.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
